// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : frame helpers, tx state encoding and parity convention for UART
// Revision : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_DONE = 2'd2
   } tx_state_t;

   localparam int TICKS_PER_BIT = 16;

   // 0 selects even parity: the parity bit is the plain XOR of the data.
   localparam logic PARITY_ODD = 1'b0;

   function automatic int baud_pulse_count(input int sysclk, input int baud);
      return sysclk / (TICKS_PER_BIT * baud);
   endfunction

   function automatic int num_frame_bits(input int data_bits, input int stop_bits);
      return 1 + data_bits + 1 + stop_bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_baud_gen : 16x oversampling tick generator with enable and sync clear
// Revision : 1.0
// ----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int BAUD_PULSE_COUNT = 10
) (
   input  logic Clk,
   input  logic Rst,
   input  logic En,
   input  logic Clr,
   output logic Tick
);

   localparam int CNT_W = (BAUD_PULSE_COUNT > 1) ? $clog2(BAUD_PULSE_COUNT) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BAUD_PULSE_COUNT - 1);

   generate
      if (BAUD_PULSE_COUNT == 0) begin : g_bad_baud
         $error("uart_baud_gen: BAUD_PULSE_COUNT must be non-zero");
      end
   endgenerate

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_cnt <= '0;
      end else if (Clr) begin
         r_cnt <= '0;
      end else if (En) begin
         r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign Tick = En && !Clr && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fsm : UART transmitter (start, data MSB first, parity, stop bits)
// Revision : 1.0
// ----------------------------------------------------------------------------
module uart_tx_fsm
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int STOP_BITS     = 2,
   parameter int SYSCLOCK_FREQ = 1_600_000,
   parameter int BAUDRATE      = 10_000
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATA_BITS-1:0] Tx_Data_In,
   input  logic                 Tx_Valid,
   input  logic                 CTS,
   output logic                 Tx_Ready,
   output logic                 Tx_Out,
   output logic                 Tx_Busy,
   output logic                 Tx_Done
);

   localparam int BAUD_PULSE_COUNT = baud_pulse_count(SYSCLOCK_FREQ, BAUDRATE);
   localparam int BIT_CYCLES       = TICKS_PER_BIT * BAUD_PULSE_COUNT;
   localparam int NUM_TX_BITS      = num_frame_bits(DATA_BITS, STOP_BITS);
   localparam int BIT_CNT_W        = $clog2(NUM_TX_BITS + 1);
   localparam int TICK_CNT_W       = $clog2(BIT_CYCLES / BAUD_PULSE_COUNT);
   localparam logic [TICK_CNT_W-1:0] C_LAST_TICK = TICK_CNT_W'(TICKS_PER_BIT - 1);
   localparam logic [BIT_CNT_W-1:0]  C_FRAME_LEN = BIT_CNT_W'(NUM_TX_BITS);

   generate
      if (BAUD_PULSE_COUNT == 0) begin : g_bad_baud
         $error("uart_tx_fsm: SYSCLOCK_FREQ too low for BAUDRATE");
      end
      if (STOP_BITS < 1) begin : g_bad_stop
         $error("uart_tx_fsm: STOP_BITS must be at least 1");
      end
   endgenerate

   tx_state_t              r_state;
   tx_state_t              w_state_next;
   logic [NUM_TX_BITS-1:0] r_shift;
   logic [NUM_TX_BITS-1:0] w_shift_next;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
   logic [TICK_CNT_W-1:0]  r_tick_cnt;
   logic [TICK_CNT_W-1:0]  w_tick_cnt_next;
   logic                   r_ready;
   logic                   r_tx_out;
   logic                   w_accept;
   logic                   w_baud_en;
   logic                   w_baud_clr;
   logic                   w_tick;
   logic                   w_parity;
   logic [NUM_TX_BITS-1:0] w_frame;

   assign w_parity = (^Tx_Data_In) ^ PARITY_ODD;
   assign w_frame  = {1'b0, Tx_Data_In, w_parity, {STOP_BITS{1'b1}}};
   assign w_accept = (r_state == TX_IDLE) && Tx_Valid && CTS && r_ready;

   uart_baud_gen #(
      .BAUD_PULSE_COUNT (BAUD_PULSE_COUNT)
   ) u_baud_gen (
      .Clk  (Clk),
      .Rst  (Rst),
      .En   (w_baud_en),
      .Clr  (w_baud_clr),
      .Tick (w_tick)
   );

   always_comb begin
      w_state_next    = r_state;
      w_shift_next    = r_shift;
      w_bit_cnt_next  = r_bit_cnt;
      w_tick_cnt_next = r_tick_cnt;
      w_baud_en       = 1'b0;
      w_baud_clr      = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (w_accept) begin
               w_shift_next    = w_frame;
               w_bit_cnt_next  = C_FRAME_LEN;
               w_tick_cnt_next = '0;
               w_baud_clr      = 1'b1;
               w_state_next    = TX_SEND;
            end
         end
         TX_SEND: begin
            w_baud_en = 1'b1;
            if (w_tick) begin
               if (r_tick_cnt == C_LAST_TICK) begin
                  // End of a bit period: present the next bit, refill with idle level.
                  w_tick_cnt_next = '0;
                  w_shift_next    = {r_shift[NUM_TX_BITS-2:0], 1'b1};
                  if (r_bit_cnt != '0) begin
                     w_bit_cnt_next = r_bit_cnt - 1'b1;
                  end
                  if (r_bit_cnt <= BIT_CNT_W'(1)) begin
                     w_state_next = TX_DONE;
                  end
               end else begin
                  w_tick_cnt_next = r_tick_cnt + 1'b1;
               end
            end
         end
         TX_DONE: begin
            w_state_next = TX_IDLE;
         end
         default: begin
            w_state_next = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state    <= TX_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_tick_cnt <= '0;
         r_ready    <= 1'b1;
         r_tx_out   <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_shift    <= w_shift_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_tick_cnt <= w_tick_cnt_next;
         r_ready    <= (w_state_next == TX_IDLE);
         r_tx_out   <= (w_state_next == TX_SEND) ? w_shift_next[NUM_TX_BITS-1] : 1'b1;
      end
   end

   assign Tx_Ready = r_ready;
   assign Tx_Out   = r_tx_out;
   assign Tx_Busy  = (r_state != TX_IDLE);
   assign Tx_Done  = (r_state == TX_DONE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_fsm : directed self-checking bench for uart_tx_fsm
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_fsm;

   localparam int BIT_CYCLES = 160;
   localparam int NBITS      = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       cts = 1'b0;
   logic       tx_ready;
   logic       tx_out;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int e0_cyc = 0;
   int prev_e0 = 0;
   int waited = 0;
   int bad = 0;
   int dones = 0;

   uart_tx_fsm dut (
      .Clk        (clk),
      .Rst        (rst),
      .Tx_Data_In (tx_data),
      .Tx_Valid   (tx_valid),
      .CTS        (cts),
      .Tx_Ready   (tx_ready),
      .Tx_Out     (tx_out),
      .Tx_Busy    (tx_busy),
      .Tx_Done    (tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offers one word, then follows the whole frame cycle by cycle and decodes
   // it at bit centres like a receiver would.
   task automatic send_frame(input string tag, input logic [7:0] data, input logic par,
                             input bit hold_valid, input logic [7:0] next_word,
                             input int cts_drop_bit, output int n_wait);
      logic [NBITS-1:0] exp_f;
      logic [NBITS-1:0] samp;
      logic [7:0]       rx;
      logic             rx_err;
      int               nbad;
      int               st_bad;
      exp_f  = {1'b0, data, par, 2'b11};
      samp   = '0;
      tx_data  = data;
      tx_valid = 1'b1;
      n_wait = 0;
      while (!(tx_ready && cts) && n_wait < 1000) begin
         @(negedge clk);
         n_wait++;
      end
      if (n_wait >= 1000) begin
         check({tag, " accept timeout"}, 32'd0, 32'd1);
         return;
      end
      @(posedge clk);
      #1;
      e0_cyc = cyc;
      if (hold_valid) begin
         tx_data = next_word;
      end else begin
         tx_valid = 1'b0;
         tx_data  = ~data;
      end
      st_bad = 0;
      for (int b = 0; b < NBITS; b++) begin
         nbad = 0;
         for (int c = 0; c < BIT_CYCLES; c++) begin
            @(negedge clk);
            if (b == cts_drop_bit && c == 0) cts = 1'b0;
            if (tx_out !== exp_f[NBITS-1-b]) nbad++;
            if (c == BIT_CYCLES/2) samp[NBITS-1-b] = tx_out;
            if (tx_busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) st_bad++;
         end
         check($sformatf("%s bit%0d wrong samples", tag, b), nbad, 0);
      end
      check({tag, " status during frame"}, st_bad, 0);
      rx     = samp[10:3];
      rx_err = (samp[11] !== 1'b0) || (samp[2] !== ^rx) || (samp[1:0] !== 2'b11);
      check({tag, " rx data"}, rx, data);
      check({tag, " rx error"}, rx_err, 0);
      @(negedge clk);
      check({tag, " done cycle {done,out,ready,busy}"}, {tx_done, tx_out, tx_ready, tx_busy}, 4'b1101);
      @(negedge clk);
      check({tag, " idle cycle {done,out,ready,busy}"}, {tx_done, tx_out, tx_ready, tx_busy}, 4'b0110);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a word offered: nothing may go out.
      rst = 1'b1; tx_valid = 1'b1; cts = 1'b1; tx_data = 8'hFF;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1) bad++;
      end
      check("during reset bad cycles", bad, 0);
      check("reset {done,out,ready,busy}", {tx_done, tx_out, tx_ready, tx_busy}, 4'b0110);
      tx_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post reset idle", {tx_done, tx_out, tx_ready, tx_busy}, 4'b0110);

      send_frame("A5", 8'hA5, 1'b0, 1'b0, 8'h00, -1, waited);
      send_frame("07", 8'h07, 1'b1, 1'b0, 8'h00, -1, waited);
      send_frame("00", 8'h00, 1'b0, 1'b0, 8'h00, -1, waited);

      // Flow control: word offered while the far end is not ready.
      cts = 1'b0; tx_valid = 1'b1; tx_data = 8'h96;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      check("cts low bad cycles", bad, 0);
      cts = 1'b1;
      send_frame("96 cts drop", 8'h96, 1'b0, 1'b0, 8'h00, 4, waited);
      check("cts raise wait cycles", waited, 0);
      cts = 1'b1;

      // Back-to-back with Tx_Valid held across both words.
      send_frame("3C", 8'h3C, 1'b0, 1'b1, 8'hC3, -1, waited);
      prev_e0 = e0_cyc;
      send_frame("C3", 8'hC3, 1'b0, 1'b0, 8'h00, -1, waited);
      check("back-to-back E0 spacing", e0_cyc - prev_e0, 1922);

      // Reset in the middle of data bit D4 (frame bit index 4) of an all-zero word.
      tx_data = 8'h00; tx_valid = 1'b1;
      bad = 0;
      while (!tx_ready && bad < 1000) begin
         @(negedge clk);
         bad++;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (4*BIT_CYCLES + 80) @(negedge clk);
      check("mid-frame line before reset", tx_out, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async reset {done,out,ready,busy}", {tx_done, tx_out, tx_ready, tx_busy}, 4'b0110);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      dones = 0;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_done) dones++;
         if (tx_out !== 1'b1) bad++;
      end
      check("abandoned frame done pulses", dones, 0);
      check("line after abandoned frame", bad, 0);

      send_frame("5A", 8'h5A, 1'b0, 1'b0, 8'h00, -1, waited);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
